// File: rtl/fpmul_pkg.sv
// Shared constants and width helpers for the three-operand floating-point multiplier.
package fpmul_pkg;

  localparam int EXP_W_DEF  = 11;
  localparam int FRAC_W_DEF = 52;
  localparam int STAGES     = 4;

  function automatic int calc_w(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpmul_norm_round.sv
// Final stage: normalise the exact 3-way mantissa product, round half-up, saturate and pack.
module fpmul_norm_round
  import fpmul_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [3*(FRAC_W+1)-1:0] prod,
  input  logic signed [EXP_W+2:0] exp_in,
  input  logic                    sign,
  input  logic                    zero,
  output logic [EXP_W+FRAC_W:0]   r,
  output logic                    ovf,
  output logic                    unf
);

  localparam int F  = FRAC_W;
  localparam int XW = EXP_W + 3;
  localparam logic signed [XW-1:0] EXP_SAT = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_MAXF = EXP_W'((1 << EXP_W) - 2);

  logic [1:0]            nshift;
  logic [F+1:0]          win;
  logic [F+1:0]          mant_rnd;
  logic                  carry;
  logic [F-1:0]          frac;
  logic signed [XW-1:0]  exp_fin;

  always_comb begin
    nshift = prod[3*F+2] ? 2'd2 : (prod[3*F+1] ? 2'd1 : 2'd0);
    // window = hidden bit, F fraction bits, then the round bit just below the LSB
    win      = prod[3*F+nshift -: F+2];
    mant_rnd = {1'b0, win[F+1:1]} + {{(F+1){1'b0}}, win[0]};
    carry    = mant_rnd[F+1];
    frac     = carry ? mant_rnd[F:1] : mant_rnd[F-1:0];
    exp_fin  = exp_in + $signed({{(XW-2){1'b0}}, nshift}) + $signed({{(XW-1){1'b0}}, carry});

    r   = '0;
    ovf = 1'b0;
    unf = 1'b0;
    if (zero) begin
      r = '0;
    end else if (exp_fin >= EXP_SAT) begin
      r   = {sign, EXP_MAXF, {F{1'b1}}};
      ovf = 1'b1;
    end else if (exp_fin <= 0) begin
      unf = 1'b1;
    end else begin
      r = {sign, exp_fin[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fpmul3_pipe.sv
// Four-stage a*b*c (or a*b) floating-point multiplier with exact mantissa product and
// a global stall driven by stopout.
module fpmul3_pipe
  import fpmul_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pushin,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic [EXP_W+FRAC_W:0] c,
  input  logic                  mode,
  input  logic                  stopout,
  output logic                  stopin,
  output logic                  pushout,
  output logic [EXP_W+FRAC_W:0] r,
  output logic                  ovf,
  output logic                  unf
);

  localparam int W    = calc_w(EXP_W, FRAC_W);
  localparam int BIAS = calc_bias(EXP_W);
  localparam int M    = FRAC_W + 1;
  localparam int XW   = EXP_W + 3;
  localparam logic [M-1:0] ONE_M = {1'b1, {FRAC_W{1'b0}}};

  logic za, zb, zc;

  logic             s1_vld, s1_mode, s1_zero, s1_sign;
  logic [EXP_W-1:0] s1_ea, s1_eb, s1_ec;
  logic [M-1:0]     s1_ma, s1_mb, s1_mc;

  logic                 s2_vld, s2_mode, s2_zero, s2_sign;
  logic signed [XW-1:0] s2_eab;
  logic [EXP_W-1:0]     s2_ec;
  logic [M-1:0]         s2_mc;
  logic [2*M-1:0]       s2_pab;

  logic                 s3_vld, s3_zero, s3_sign;
  logic signed [XW-1:0] s3_exp;
  logic [3*M-1:0]       s3_prod;

  logic [M-1:0]  mc_eff;
  logic [XW-1:0] ec_adj;
  logic [W-1:0]  n_r;
  logic          n_ovf, n_unf;

  assign stopin = stopout;
  assign za = (a[W-2:0] == '0);
  assign zb = (b[W-2:0] == '0);
  assign zc = (c[W-2:0] == '0);

  // mode 1 runs c as exactly 1.0 so the S3 product keeps the same alignment
  always_comb begin
    mc_eff = s2_mode ? ONE_M : s2_mc;
    ec_adj = s2_mode ? '0 : (XW'(s2_ec) - XW'(BIAS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;  s1_mode <= 1'b0;  s1_zero <= 1'b0;  s1_sign <= 1'b0;
      s1_ea   <= '0;    s1_eb   <= '0;    s1_ec   <= '0;
      s1_ma   <= '0;    s1_mb   <= '0;    s1_mc   <= '0;
      s2_vld  <= 1'b0;  s2_mode <= 1'b0;  s2_zero <= 1'b0;  s2_sign <= 1'b0;
      s2_eab  <= '0;    s2_ec   <= '0;    s2_mc   <= '0;    s2_pab  <= '0;
      s3_vld  <= 1'b0;  s3_zero <= 1'b0;  s3_sign <= 1'b0;
      s3_exp  <= '0;    s3_prod <= '0;
      pushout <= 1'b0;  r       <= '0;    ovf     <= 1'b0;  unf     <= 1'b0;
    end else if (!stopout) begin
      s1_vld  <= pushin;
      s1_mode <= mode;
      s1_zero <= za | zb | (zc & ~mode);
      s1_sign <= a[W-1] ^ b[W-1] ^ (c[W-1] & ~mode);
      s1_ea   <= a[W-2:FRAC_W];
      s1_eb   <= b[W-2:FRAC_W];
      s1_ec   <= c[W-2:FRAC_W];
      s1_ma   <= {1'b1, a[FRAC_W-1:0]};
      s1_mb   <= {1'b1, b[FRAC_W-1:0]};
      s1_mc   <= {1'b1, c[FRAC_W-1:0]};

      s2_vld  <= s1_vld;
      s2_mode <= s1_mode;
      s2_zero <= s1_zero;
      s2_sign <= s1_sign;
      s2_eab  <= XW'(s1_ea) + XW'(s1_eb) - XW'(BIAS);
      s2_ec   <= s1_ec;
      s2_mc   <= s1_mc;
      s2_pab  <= {{M{1'b0}}, s1_ma} * {{M{1'b0}}, s1_mb};

      s3_vld  <= s2_vld;
      s3_zero <= s2_zero;
      s3_sign <= s2_sign;
      s3_exp  <= s2_eab + ec_adj;
      s3_prod <= {{M{1'b0}}, s2_pab} * {{(2*M){1'b0}}, mc_eff};

      pushout <= s3_vld;
      r       <= n_r;
      ovf     <= n_ovf;
      unf     <= n_unf;
    end
  end

  fpmul_norm_round #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_norm_round (
    .prod   (s3_prod),
    .exp_in (s3_exp),
    .sign   (s3_sign),
    .zero   (s3_zero),
    .r      (n_r),
    .ovf    (n_ovf),
    .unf    (n_unf)
  );

endmodule

// File: tb/tb_fpmul3_pipe.sv
// Directed and randomized checks of fpmul3_pipe (double and half formats) against an
// arbitrary-precision reference model.
module tb_fpmul3_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin, mode, stopout, stopin, pushout, ovf, unf;
  logic [63:0] a, b, c, r;

  logic        pushin_h, mode_h, stopout_h, stopin_h, pushout_h, ovf_h, unf_h;
  logic [15:0] a_h, b_h, c_h, r_h;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpmul3_pipe dut (
    .clk(clk), .rst(rst), .pushin(pushin), .a(a), .b(b), .c(c), .mode(mode),
    .stopout(stopout), .stopin(stopin), .pushout(pushout), .r(r), .ovf(ovf), .unf(unf)
  );

  fpmul3_pipe #(.EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .rst(rst), .pushin(pushin_h), .a(a_h), .b(b_h), .c(c_h), .mode(mode_h),
    .stopout(stopout_h), .stopin(stopin_h), .pushout(pushout_h), .r(r_h), .ovf(ovf_h), .unf(unf_h)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact value model: integer mantissa product, locate its leading one, round half-up.
  function automatic logic [63:0] ref_mul(input int ew, input int fw,
                                          input logic [63:0] ia, input logic [63:0] ib,
                                          input logic [63:0] ic, input bit md,
                                          output bit o_ovf, output bit o_unf);
    longint bias, ea, eb, ec, ex;
    logic [63:0] em, fm;
    logic [191:0] ma, mb, mc, p, qq;
    int k;
    bit sg;
    o_ovf = 1'b0;
    o_unf = 1'b0;
    bias = (longint'(1) << (ew - 1)) - 1;
    em = (64'd1 << ew) - 64'd1;
    fm = (64'd1 << fw) - 64'd1;
    if ((((ia >> fw) & em) == 0 && (ia & fm) == 0) ||
        (((ib >> fw) & em) == 0 && (ib & fm) == 0) ||
        (!md && ((ic >> fw) & em) == 0 && (ic & fm) == 0))
      return 64'd0;
    sg = ia[ew+fw] ^ ib[ew+fw] ^ (md ? 1'b0 : ic[ew+fw]);
    ea = longint'((ia >> fw) & em);
    eb = longint'((ib >> fw) & em);
    ec = md ? bias : longint'((ic >> fw) & em);
    ma = 192'(ia & fm) | (192'd1 << fw);
    mb = 192'(ib & fm) | (192'd1 << fw);
    mc = md ? (192'd1 << fw) : (192'(ic & fm) | (192'd1 << fw));
    p = ma * mb * mc;
    k = 0;
    for (int i = 0; i < 192; i++) if (p[i]) k = i;
    qq = (p + (192'd1 << (k - fw - 1))) >> (k - fw);
    ex = ea + eb + ec - 2 * bias + longint'(k - 3 * fw);
    if ((qq >> (fw + 1)) != 0) begin
      qq = qq >> 1;
      ex++;
    end
    if (ex >= (longint'(1) << ew) - 1) begin
      o_ovf = 1'b1;
      return (64'(sg) << (ew + fw)) | (64'((longint'(1) << ew) - 2) << fw) | fm;
    end
    if (ex <= 0) begin
      o_unf = 1'b1;
      return 64'd0;
    end
    return (64'(sg) << (ew + fw)) | (64'(ex) << fw) | (qq[63:0] & fm);
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] e, f;
    logic s;
    int sel;
    sel = $urandom_range(0, 15);
    s = 1'($urandom_range(0, 1));
    f = {$urandom, $urandom} & 64'h000F_FFFF_FFFF_FFFF;
    if (sel == 0) return {s, 63'd0};
    if (sel == 1) e = 64'($urandom_range(0, 2047));
    else if (sel == 2) e = 64'($urandom_range(1900, 2047));
    else if (sel == 3) e = 64'($urandom_range(0, 300));
    else e = 64'($urandom_range(993, 1053));
    if (sel == 4) f = 64'h000F_FFFF_FFFF_FFFF;
    return {s, e[10:0], f[51:0]};
  endfunction

  task automatic run_one(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] ic, input logic im, input logic [63:0] er,
                         input logic eo, input logic eu);
    bit mo, mu;
    a = ia; b = ib; c = ic; mode = im; pushin = 1'b1;
    tick();
    pushin = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_early_pushout"}, 64'(pushout), 64'd0);
      tick();
    end
    chk({tag, "_pushout"}, 64'(pushout), 64'd1);
    chk({tag, "_r"}, r, er);
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_unf"}, 64'(unf), 64'(eu));
    chk({tag, "_model"}, r, ref_mul(11, 52, ia, ib, ic, im, mo, mu));
    tick();
    chk({tag, "_bubble"}, 64'(pushout), 64'd0);
  endtask

  task automatic run_h(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ic, input logic [15:0] er);
    a_h = ia; b_h = ib; c_h = ic; mode_h = 1'b0; pushin_h = 1'b1;
    tick();
    pushin_h = 1'b0;
    repeat (3) tick();
    chk({tag, "_pushout"}, 64'(pushout_h), 64'd1);
    chk({tag, "_r"}, 64'(r_h), 64'(er));
    chk({tag, "_flags"}, 64'({ovf_h, unf_h}), 64'd0);
  endtask

  task automatic stream(input int n_ops, input int st_lo, input int st_hi, input bit rnd);
    logic [65:0] q[$];
    logic [65:0] e;
    logic [63:0] ca, cb, cc, er, prev_r;
    logic cm, prev_po, was_stall;
    bit eo, eu;
    int idx, cyc;
    idx = 0;
    cyc = 0;
    ca = rand_op(); cb = rand_op(); cc = rand_op(); cm = 1'($urandom_range(0, 1));
    while ((idx < n_ops || q.size() > 0) && cyc < n_ops * 6 + 40) begin
      stopout = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= st_lo && cyc <= st_hi);
      pushin = (idx < n_ops) && (rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
      a = ca; b = cb; c = cc; mode = cm;
      #1;
      if (pushout && !stopout) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_result", 64'(pushout), 64'd0);
        end else begin
          e = q.pop_front();
          chk("stream_r", r, e[63:0]);
          chk("stream_flags", 64'({ovf, unf}), 64'(e[65:64]));
        end
      end
      if (pushin && !stopout) begin
        er = ref_mul(11, 52, ca, cb, cc, cm, eo, eu);
        q.push_back({eo, eu, er});
        idx++;
        ca = rand_op(); cb = rand_op(); cc = rand_op(); cm = 1'($urandom_range(0, 1));
      end
      prev_r = r;
      prev_po = pushout;
      was_stall = stopout;
      tick();
      if (was_stall) begin
        chk("stall_hold_r", r, prev_r);
        chk("stall_hold_pushout", 64'(pushout), 64'(prev_po));
      end
      cyc++;
    end
    chk("stream_all_results_seen", 64'(q.size()), 64'd0);
    pushin = 1'b0;
    stopout = 1'b0;
    repeat (6) tick();
    chk("stream_idle_after", 64'(pushout), 64'd0);
  endtask

  initial begin
    logic [63:0] op_a, op_b, op_c, er;
    bit eo, eu;

    rst = 1'b0;
    pushin = 1'b0; mode = 1'b0; stopout = 1'b1; a = '0; b = '0; c = '0;
    pushin_h = 1'b0; mode_h = 1'b0; stopout_h = 1'b0; a_h = '0; b_h = '0; c_h = '0;
    tick();
    chk("reset_stopin_high", 64'(stopin), 64'd1);
    chk("reset_pushout", 64'(pushout), 64'd0);
    chk("reset_r", r, 64'd0);
    chk("reset_flags", 64'({ovf, unf}), 64'd0);
    stopout = 1'b0;
    #1;
    chk("reset_stopin_low", 64'(stopin), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    run_one("cube_1p5", 64'h3FF8000000000000, 64'h3FF8000000000000, 64'h3FF8000000000000,
            1'b0, 64'h400B000000000000, 1'b0, 1'b0);
    run_one("mode1_c_zero", 64'hC000000000000000, 64'h4000000000000000, 64'h0,
            1'b1, 64'hC010000000000000, 1'b0, 1'b0);
    run_one("overflow", 64'h7FE0000000000000, 64'h7FE0000000000000, 64'h3FF0000000000000,
            1'b0, 64'h7FEFFFFFFFFFFFFF, 1'b1, 1'b0);
    run_one("underflow", 64'h0010000000000000, 64'h0010000000000000, 64'h0010000000000000,
            1'b0, 64'h0, 1'b0, 1'b1);
    run_one("neg_zero_operand", 64'h4000000000000000, 64'h8000000000000000, 64'hC000000000000000,
            1'b0, 64'h0, 1'b0, 1'b0);

    er = ref_mul(5, 10, 64'h3E00, 64'h3E00, 64'h3E00, 1'b0, eo, eu);
    run_h("half_cube_1p5", 16'h3E00, 16'h3E00, 16'h3E00, er[15:0]);
    run_h("half_round", 16'h3FFF, 16'h3C01, 16'h3C00, 16'h4000);

    stream(8, 5, 7, 1'b0);

    // three operations in flight behind a valid output when reset hits
    pushin = 1'b1; stopout = 1'b0; mode = 1'b0;
    op_a = 64'h3FF8000000000000; op_b = 64'h4000000000000000; op_c = 64'hBFF0000000000000;
    a = op_a; b = op_b; c = op_c;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = rand_op(); b = rand_op(); c = rand_op();
      tick();
    end
    chk("pre_reset_pushout", 64'(pushout), 64'd1);
    chk("pre_reset_r", r, ref_mul(11, 52, op_a, op_b, op_c, 1'b0, eo, eu));
    rst = 1'b0;
    pushin = 1'b0;
    #1;
    chk("async_reset_pushout", 64'(pushout), 64'd0);
    chk("async_reset_r", r, 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_after_reset", 64'(pushout), 64'd0);
    end
    run_one("after_reset", 64'h3FF8000000000000, 64'h3FF8000000000000, 64'h3FF8000000000000,
            1'b0, 64'h400B000000000000, 1'b0, 1'b0);

    stream(300, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
